bsg_manycore_drlp_sync_collector: RTL

//  Sits between the DRLP slave tiles and the DRLP master tile in the bottom row of bsg_manycore.

---
 rtl/bsg_manycore_drlp_sync_collector.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/bsg_manycore_drlp_sync_collector.sv
`default_nettype none
// ============================================================================
//  Module   : bsg_manycore_drlp_sync_collector
//  Purpose  : Collects the per-slave pe_ready / slave_done handshakes of the
//             DRLP slave tiles into single all_pe_ready / all_slave_done
//             pulses for the DRLP master tile. Each phase captures the
//             handshakes sticky-wise, honours a per-phase slave enable mask,
//             and a watchdog reports which slaves never answered.
//  Ports    : clk_i             core clock
//             reset_i           synchronous active-high reset
//             start_i           pulse: a new phase begins (samples slave_mask_i)
//             slave_mask_i      1 = slave participates in the phase
//             pe_ready_i        per-slave ready (level or pulse)
//             slave_done_i      per-slave done (level or pulse)
//             all_pe_ready_o    1-cycle pulse: every masked slave was ready
//             all_slave_done_o  1-cycle pulse: every masked slave was done
//             busy_o            high while waiting for ready or done
//             timeout_o         sticky: watchdog expired in current/last phase
//             timeout_slave_o   masked slaves that had not answered at expiry
//  Revision : 1.0  initial release
// ============================================================================
module bsg_manycore_drlp_sync_collector #(
    parameter int num_slaves_p    = 4,
    parameter int timeout_width_p = 16
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       start_i,
    input  logic [num_slaves_p-1:0]    slave_mask_i,
    input  logic [num_slaves_p-1:0]    pe_ready_i,
    input  logic [num_slaves_p-1:0]    slave_done_i,
    output logic                       all_pe_ready_o,
    output logic                       all_slave_done_o,
    output logic                       busy_o,
    output logic                       timeout_o,
    output logic [num_slaves_p-1:0]    timeout_slave_o
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_READY = 2'd1,
        WAIT_DONE  = 2'd2
    } state_e;

    localparam logic [timeout_width_p-1:0] wd_one = timeout_width_p'(1);

    state_e                      state, state_n;
    logic [num_slaves_p-1:0]     mask_r, mask_n;
    logic [num_slaves_p-1:0]     ready_r, ready_n;
    logic [num_slaves_p-1:0]     done_r, done_n;
    logic [timeout_width_p-1:0]  wd_cnt, wd_n;
    logic                        pe_pulse_n;
    logic                        done_pulse_n;
    logic                        timeout_n;
    logic [num_slaves_p-1:0]     timeout_slave_n;

    // Sticky sets including this cycle's answers; completion is judged on
    // these so a completing input is reflected one cycle later.
    logic [num_slaves_p-1:0]     ready_merge;
    logic [num_slaves_p-1:0]     done_merge;
    logic                        wd_expired;
    logic [timeout_width_p-1:0]  wd_inc;

    assign ready_merge = ready_r | (pe_ready_i & mask_r);
    assign done_merge  = done_r  | (slave_done_i & mask_r);
    assign wd_expired  = &wd_cnt;
    // Saturating increment: the counter never wraps back to zero.
    assign wd_inc      = wd_expired ? wd_cnt : (wd_cnt + wd_one);

    assign busy_o = (state == WAIT_READY) || (state == WAIT_DONE);

    always_comb begin
        state_n         = state;
        mask_n          = mask_r;
        ready_n         = ready_r;
        done_n          = done_r;
        wd_n            = wd_cnt;
        pe_pulse_n      = 1'b0;
        done_pulse_n    = 1'b0;
        timeout_n       = timeout_o;
        timeout_slave_n = timeout_slave_o;

        if (start_i) begin
            // A start wins in every state; handshakes in this cycle belong
            // to no phase and are dropped.
            mask_n          = slave_mask_i;
            ready_n         = '0;
            done_n          = '0;
            wd_n            = '0;
            timeout_n       = 1'b0;
            timeout_slave_n = '0;
            state_n         = WAIT_READY;
        end else begin
            case (state)
                WAIT_READY: begin
                    ready_n = ready_merge;
                    // Done is collected early so a fast slave is not lost.
                    done_n  = done_merge;
                    if (ready_merge == mask_r) begin
                        pe_pulse_n = 1'b1;
                        wd_n       = '0;
                        state_n    = WAIT_DONE;
                    end else if (wd_expired) begin
                        timeout_n       = 1'b1;
                        timeout_slave_n = mask_r & ~ready_r;
                        wd_n            = '0;
                        state_n         = IDLE;
                    end else begin
                        wd_n = wd_inc;
                    end
                end
                WAIT_DONE: begin
                    done_n = done_merge;
                    if (done_merge == mask_r) begin
                        done_pulse_n = 1'b1;
                        wd_n         = '0;
                        state_n      = IDLE;
                    end else if (wd_expired) begin
                        timeout_n       = 1'b1;
                        timeout_slave_n = mask_r & ~done_r;
                        wd_n            = '0;
                        state_n         = IDLE;
                    end else begin
                        wd_n = wd_inc;
                    end
                end
                default: begin
                    // IDLE: handshakes are ignored.
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state            <= IDLE;
            mask_r           <= '0;
            ready_r          <= '0;
            done_r           <= '0;
            wd_cnt           <= '0;
            all_pe_ready_o   <= 1'b0;
            all_slave_done_o <= 1'b0;
            timeout_o        <= 1'b0;
            timeout_slave_o  <= '0;
        end else begin
            state            <= state_n;
            mask_r           <= mask_n;
            ready_r          <= ready_n;
            done_r           <= done_n;
            wd_cnt           <= wd_n;
            all_pe_ready_o   <= pe_pulse_n;
            all_slave_done_o <= done_pulse_n;
            timeout_o        <= timeout_n;
            timeout_slave_o  <= timeout_slave_n;
        end
    end

endmodule
`default_nettype wire
